// File: rtl/ib_mac_seq.sv
// ib_mac_seq: operand sequencer and dot-product accumulator around ib_mul.
// Optional saturating accumulate with sticky o_sat: define IB_MAC_SAT_EN.
module ib_mac_seq #(
    parameter int ACC_W  = 24,
    parameter int TO_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    input  logic             i_last,
    output logic             o_mul_start,
    output logic [7:0]       o_mul_a,
    output logic [7:0]       o_mul_b,
    input  logic [15:0]      i_mul_c,
    input  logic             i_mul_done,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_acc_valid,
    output logic             o_err,
    output logic             o_sat
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_BLANK, S_WAIT, S_OUT
    } state_t;

    localparam int CW = $clog2(TO_CYC + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_acc_out;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic             r_last;
    logic             r_start;
    logic             r_acc_valid;
    logic             r_err;
    logic [ACC_W-1:0] w_acc_next;

`ifdef IB_MAC_SAT_EN
    logic [ACC_W:0]   w_sum;
    logic             r_sat;
    logic             r_sat_out;

    assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(i_mul_c);
    assign w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign o_sat      = r_sat_out;

    // Sticky per-frame flag; cleared when a frame ends so the next one starts clean.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sat     <= 1'b0;
            r_sat_out <= 1'b0;
        end else if (r_state == S_WAIT && i_mul_done) begin
            if (w_sum[ACC_W]) r_sat <= 1'b1;
        end else if (r_state == S_WAIT && r_cnt == CW'(TO_CYC - 1)) begin
            r_sat     <= 1'b0;
            r_sat_out <= 1'b0;
        end else if (r_state == S_OUT) begin
            r_sat_out <= r_sat;
            r_sat     <= 1'b0;
        end
    end
`else
    assign w_acc_next = r_acc + ACC_W'(i_mul_c);
    assign o_sat      = 1'b0;
`endif

    assign o_ready     = (r_state == S_IDLE);
    assign o_mul_start = r_start;
    assign o_mul_a     = r_a;
    assign o_mul_b     = r_b;
    assign o_acc       = r_acc_out;
    assign o_acc_valid = r_acc_valid;
    assign o_err       = r_err;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= 1'b0;
            r_start     <= 1'b0;
            r_acc_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_acc_valid <= 1'b0;
            r_err       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_last  <= i_last;
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_BLANK;
                // Stale done from the previous op may still be high here.
                S_BLANK: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mul_done) begin
                        r_acc   <= w_acc_next;
                        r_state <= r_last ? S_OUT : S_IDLE;
                    end else if (r_cnt == CW'(TO_CYC - 1)) begin
                        r_err   <= 1'b1;
                        r_acc   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_OUT: begin
                    r_acc_out   <= r_acc;
                    r_acc_valid <= 1'b1;
                    r_acc       <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
